// File: rtl/ahb_master_ctrl.sv
// AHB-lite single-beat master controller: ping-pong staging of command addresses
// into two external HADDR registers, with pipelined address/data phases and error retry.
module ahb_master_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] data_in1,
    output logic [ADDR_W-1:0] data_in2,
    output logic              sel1,
    output logic              sel2,
    output logic              mux1,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_PIPE
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        slot_vld_q, slot_vld_d;
    logic [1:0]        slot_write_q, slot_write_d;
    logic [DATA_W-1:0] slot_wdata_q [2];
    logic [DATA_W-1:0] slot_wdata_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              iss_ptr_q, iss_ptr_d;
    logic              dp_vld_q, dp_vld_d;
    logic              dp_write_q, dp_write_d;
    logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
    logic              mux1_q, mux1_d;
    logic [ADDR_W-1:0] data_in1_q, data_in1_d;
    logic [ADDR_W-1:0] data_in2_q, data_in2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic addr_act, data_act, addr_done, data_done, err_first, accept;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        slot_vld_d   = slot_vld_q;
        slot_write_d = slot_write_q;
        slot_wdata_d = slot_wdata_q;
        wr_ptr_d     = wr_ptr_q;
        iss_ptr_d    = iss_ptr_q;
        dp_vld_d     = dp_vld_q;
        dp_write_d   = dp_write_q;
        dp_wdata_d   = dp_wdata_q;
        sel1         = 1'b0;
        sel2         = 1'b0;
        data_in1     = data_in1_q;
        data_in2     = data_in2_q;

        addr_act  = (state_q == ST_ADDR) || (state_q == ST_PIPE);
        data_act  = (state_q == ST_DATA) || (state_q == ST_PIPE);
        addr_done = addr_act && hready;
        data_done = data_act && hready;
        err_first = data_act && hresp && !hready;

        // A full queue can still accept when the issuing slot frees at this edge.
        cmd_ready = !rst && (!(&slot_vld_q) || addr_done);
        accept    = cmd_valid && cmd_ready;

        rsp_valid_d = data_done;
        rsp_rdata_d = (data_done && !dp_write_q) ? hrdata : '0;
        rsp_err_d   = data_done && hresp;

        if (data_done) begin
            dp_vld_d = 1'b0;
        end
        if (addr_done) begin
            slot_vld_d[iss_ptr_q] = 1'b0;
            iss_ptr_d             = !iss_ptr_q;
            dp_vld_d              = 1'b1;
            dp_write_d            = slot_write_q[iss_ptr_q];
            dp_wdata_d            = slot_wdata_q[iss_ptr_q];
        end
        if (accept) begin
            slot_vld_d[wr_ptr_q]   = 1'b1;
            slot_write_d[wr_ptr_q] = cmd_write;
            slot_wdata_d[wr_ptr_q] = cmd_wdata;
            wr_ptr_d               = !wr_ptr_q;
            if (!wr_ptr_q) begin
                sel1     = 1'b1;
                data_in1 = cmd_addr;
            end else begin
                sel2     = 1'b1;
                data_in2 = cmd_addr;
            end
        end
        data_in1_d = data_in1;
        data_in2_d = data_in2;

        // First error cycle drops the pending address phase; the slot stays queued for reissue.
        if (hready) begin
            case ({slot_vld_d[iss_ptr_d], dp_vld_d})
                2'b00:   state_d = ST_IDLE;
                2'b10:   state_d = ST_ADDR;
                2'b01:   state_d = ST_DATA;
                default: state_d = ST_PIPE;
            endcase
        end else if (err_first) begin
            state_d = ST_DATA;
        end

        htrans = addr_act ? HTRANS_NONSEQ : HTRANS_IDLE;
        mux1   = addr_act ? iss_ptr_q : mux1_q;
        mux1_d = mux1;
        hwrite = addr_act && slot_write_q[iss_ptr_q];
        hwdata = (data_act && dp_write_q) ? dp_wdata_q : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only; the tiny slot store is
    // reset along with everything else so no X can leak onto hwdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            slot_vld_q      <= '0;
            slot_write_q    <= '0;
            slot_wdata_q[0] <= '0;
            slot_wdata_q[1] <= '0;
            wr_ptr_q        <= 1'b0;
            iss_ptr_q       <= 1'b0;
            dp_vld_q        <= 1'b0;
            dp_write_q      <= 1'b0;
            dp_wdata_q      <= '0;
            mux1_q          <= 1'b0;
            data_in1_q      <= '0;
            data_in2_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_vld_q      <= slot_vld_d;
            slot_write_q    <= slot_write_d;
            slot_wdata_q[0] <= slot_wdata_d[0];
            slot_wdata_q[1] <= slot_wdata_d[1];
            wr_ptr_q        <= wr_ptr_d;
            iss_ptr_q       <= iss_ptr_d;
            dp_vld_q        <= dp_vld_d;
            dp_write_q      <= dp_write_d;
            dp_wdata_q      <= dp_wdata_d;
            mux1_q          <= mux1_d;
            data_in1_q      <= data_in1_d;
            data_in2_q      <= data_in2_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: reset, single read, back-to-back writes,
// wait states, error retry and mid-pipeline reset, with hand-computed expectations.
module tb_ahb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic        cmd_write;
    logic [15:0] cmd_wdata;
    logic [15:0] data_in1, data_in2;
    logic        sel1, sel2, mux1;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic        hready, hresp;
    logic [15:0] hrdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int n_pass   = 0;
    int n_checks = 0;

    ahb_master_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .data_in1(data_in1), .data_in2(data_in2), .sel1(sel1), .sel2(sel2),
        .mux1(mux1), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic cmd(input logic [15:0] a, input logic w, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b1; cmd_addr = 16'h1234; cmd_write = 1'b0;
        cmd_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;

        // Reset held for two edges with a command offered
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_sel1", sel1, 0);
            chk("rst_sel2", sel2, 0);
            chk("rst_htrans", htrans, 2'b00);
            chk("rst_rsp_valid", rsp_valid, 0);
        end

        // Single read 0x0104
        rst = 1'b0; cmd(16'h0104, 1'b0, 16'h0000); #1;
        chk("rd_ready", cmd_ready, 1);
        chk("rd_sel1", sel1, 1);
        chk("rd_sel2", sel2, 0);
        chk("rd_data_in1", data_in1, 16'h0104);
        chk("rd_htrans_t", htrans, 2'b00);
        cyc(); cmd_valid = 1'b0; #1;
        chk("rd_htrans_t1", htrans, 2'b10);
        chk("rd_mux1_t1", mux1, 0);
        chk("rd_hwrite_t1", hwrite, 0);
        chk("rd_sel1_t1", sel1, 0);
        cyc(); hrdata = 16'hBEEF; #1;
        chk("rd_htrans_t2", htrans, 2'b00);
        chk("rd_mux1_hold", mux1, 0);
        chk("rd_rsp_t2", rsp_valid, 0);
        cyc(); hrdata = 16'h0000; #1;
        chk("rd_rsp_t3", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 16'hBEEF);
        chk("rd_err", rsp_err, 0);
        cyc(); #1;
        chk("rd_rsp_t4", rsp_valid, 0);

        // Back-to-back writes from a fresh reset
        do_reset(); hrdata = 16'hDEAD;
        cmd(16'h0010, 1'b1, 16'h1111); #1;
        chk("wr0_sel1", sel1, 1);
        chk("wr0_sel2", sel2, 0);
        chk("wr0_data_in1", data_in1, 16'h0010);
        cyc(); cmd(16'h0200, 1'b1, 16'h2222); #1;
        chk("wr1_ready", cmd_ready, 1);
        chk("wr1_sel2", sel2, 1);
        chk("wr1_sel1", sel1, 0);
        chk("wr1_data_in2", data_in2, 16'h0200);
        chk("wr1_htrans", htrans, 2'b10);
        chk("wr1_mux1", mux1, 0);
        chk("wr1_hwrite", hwrite, 1);
        cyc(); cmd(16'h0030, 1'b1, 16'h3333); #1;
        chk("wr2_sel1", sel1, 1);
        chk("wr2_data_in1", data_in1, 16'h0030);
        chk("wr2_data_in2_hold", data_in2, 16'h0200);
        chk("wr2_mux1", mux1, 1);
        chk("wr2_hwdata", hwdata, 16'h1111);
        cyc(); cmd_valid = 1'b0; #1;
        chk("wr3_htrans", htrans, 2'b10);
        chk("wr3_mux1", mux1, 0);
        chk("wr3_hwdata", hwdata, 16'h2222);
        chk("wr3_rsp", rsp_valid, 1);
        chk("wr3_rdata_zero", rsp_rdata, 16'h0000);
        cyc(); #1;
        chk("wr4_htrans", htrans, 2'b00);
        chk("wr4_hwdata", hwdata, 16'h3333);
        chk("wr4_rsp", rsp_valid, 1);
        cyc(); #1;
        chk("wr5_rsp", rsp_valid, 1);
        chk("wr5_hwdata", hwdata, 16'h0000);
        cyc(); #1;
        chk("wr6_rsp", rsp_valid, 0);

        // Wait states in the data phase of read A while B is in its address phase
        do_reset(); hrdata = '0;
        cmd(16'h0500, 1'b0, 16'h0000);
        cyc(); cmd(16'h0600, 1'b0, 16'h0000);
        cyc(); cmd(16'h0700, 1'b0, 16'h0000); hready = 1'b0; #1;
        chk("ws0_ready", cmd_ready, 1);
        chk("ws0_sel1", sel1, 1);
        chk("ws0_mux1", mux1, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); cmd(16'h0800, 1'b0, 16'h0000); #1;
            chk("ws_ready_full", cmd_ready, 0);
            chk("ws_sel1", sel1, 0);
            chk("ws_sel2", sel2, 0);
            chk("ws_htrans", htrans, 2'b10);
            chk("ws_mux1", mux1, 1);
            chk("ws_data_in2", data_in2, 16'h0600);
            chk("ws_rsp", rsp_valid, 0);
        end
        cyc(); cmd_valid = 1'b0; hready = 1'b1; hrdata = 16'hA5A5; #1;
        chk("ws5_ready_free", cmd_ready, 1);
        chk("ws5_mux1", mux1, 1);
        cyc(); hrdata = 16'h5A5A; #1;
        chk("ws6_rsp", rsp_valid, 1);
        chk("ws6_rdata", rsp_rdata, 16'hA5A5);
        chk("ws6_mux1", mux1, 0);
        cyc(); hrdata = 16'h0C0C; #1;
        chk("ws7_rsp", rsp_valid, 1);
        chk("ws7_rdata", rsp_rdata, 16'h5A5A);
        chk("ws7_htrans", htrans, 2'b00);
        cyc(); hrdata = '0; #1;
        chk("ws8_rsp", rsp_valid, 1);
        chk("ws8_rdata", rsp_rdata, 16'h0C0C);
        cyc(); #1;
        chk("ws9_rsp", rsp_valid, 0);

        // Error on write 0x0300 with read 0x0400 pending
        do_reset();
        cmd(16'h0300, 1'b1, 16'hCAFE);
        cyc(); cmd(16'h0400, 1'b0, 16'h0000);
        cyc(); cmd_valid = 1'b0; hresp = 1'b1; hready = 1'b0; #1;
        chk("er2_htrans", htrans, 2'b10);
        chk("er2_hwdata", hwdata, 16'hCAFE);
        cyc(); hready = 1'b1; #1;
        chk("er3_htrans_idle", htrans, 2'b00);
        chk("er3_mux1", mux1, 1);
        cyc(); hresp = 1'b0; #1;
        chk("er4_htrans", htrans, 2'b10);
        chk("er4_mux1", mux1, 1);
        chk("er4_hwrite", hwrite, 0);
        chk("er4_rsp", rsp_valid, 1);
        chk("er4_err", rsp_err, 1);
        cyc(); hrdata = 16'h4444; #1;
        chk("er5_htrans", htrans, 2'b00);
        chk("er5_rsp", rsp_valid, 0);
        cyc(); hrdata = '0; #1;
        chk("er6_rsp", rsp_valid, 1);
        chk("er6_rdata", rsp_rdata, 16'h4444);
        chk("er6_err", rsp_err, 0);

        // Reset asserted in the middle of a pipelined pair
        do_reset();
        cmd(16'h0900, 1'b0, 16'h0000);
        cyc(); cmd(16'h0A00, 1'b0, 16'h0000);
        cyc(); cmd_valid = 1'b0; rst = 1'b1; #1;
        chk("mr_pipe_htrans", htrans, 2'b10);
        chk("mr_ready_in_rst", cmd_ready, 0);
        cyc(); rst = 1'b0; cmd(16'h0B00, 1'b0, 16'h0000); #1;
        chk("mr_htrans", htrans, 2'b00);
        chk("mr_rsp", rsp_valid, 0);
        chk("mr_sel1", sel1, 1);
        chk("mr_sel2", sel2, 0);
        chk("mr_data_in1", data_in1, 16'h0B00);
        cyc(); cmd(16'h0C00, 1'b0, 16'h0000); #1;
        chk("mr_ready_2nd", cmd_ready, 1);
        chk("mr_sel2_2nd", sel2, 1);
        cyc(); cmd_valid = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
